// File: rtl/serial_r.sv
// -----------------------------------------------------------------------------
// serial_r : 8N1 UART receiver, downstream partner of the serial_s transmitter.
//
// Rebuilds each byte from the serial line (LSB first). A good frame presents
// the byte on dataout together with a one-cycle valid pulse. A frame whose
// stop bit samples low gives a one-cycle frame_err pulse instead and leaves
// dataout untouched.
//
// Parameters
//   BIT_CYC   m_clock cycles per serial bit (8..65535)
//   HALF_CYC  cycles from start-edge detect to the start-bit centre sample
//
// Ports
//   m_clock    in   system clock, rising edge
//   p_reset_n  in   asynchronous reset, active-low
//   RDX        in   serial line, idles high, asynchronous to m_clock
//   dataout    out  [7:0] last correctly received byte
//   valid      out  one-cycle pulse, dataout is new in the same cycle
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   busy       out  high in every state except IDLE
//
// Build option
//   SERIAL_R_MAJORITY_EN : every sample point takes rx_s at P-1, P and P+1
//   and uses the 2-of-3 majority; the state advances at P+1.
// -----------------------------------------------------------------------------
module serial_r #(
  parameter int unsigned BIT_CYC  = 5201,
  parameter int unsigned HALF_CYC = BIT_CYC / 2
) (
  input  logic       m_clock,
  input  logic       p_reset_n,
  input  logic       RDX,
  output logic [7:0] dataout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

`ifdef SERIAL_R_MAJORITY_EN
  localparam int unsigned ADV_OFS = 1;
`else
  localparam int unsigned ADV_OFS = 0;
`endif

  // Count at which each state takes its decision: the nominal sample point,
  // or one cycle later when the majority window is in use.
  localparam logic [15:0] START_ADV = 16'(HALF_CYC - 1 + ADV_OFS);
  localparam logic [15:0] BIT_ADV   = 16'(BIT_CYC - 1 + ADV_OFS);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        rx_m;
  logic        rx_s;

  logic [15:0] adv_cnt;
  logic        at_adv;
  logic        bit_val;

  // Two-flop synchronizer; both flops reset to the idle line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RDX;
      rx_s <= rx_m;
    end
  end

  always_comb begin
    adv_cnt = BIT_ADV;
    if (state == ST_START) begin
      adv_cnt = START_ADV;
    end
  end

  assign at_adv = (cnt == adv_cnt);

`ifdef SERIAL_R_MAJORITY_EN
  logic s_early;
  logic s_mid;

  // Captures run in every state; only the values at a decision point matter.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (cnt == adv_cnt - 16'd2) begin
        s_early <= rx_s;
      end
      if (cnt == adv_cnt - 16'd1) begin
        s_mid <= rx_s;
      end
    end
  end

  assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      dataout   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (at_adv) begin
            cnt   <= '0;
            idx   <= '0;
            // A high sample at the start-bit centre is a glitch, not a frame.
            state <= bit_val ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (at_adv) begin
            cnt        <= '0;
            shift[idx] <= bit_val;
            if (idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (at_adv) begin
            cnt <= '0;
            if (bit_val) begin
              dataout <= shift;
              valid   <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a stuck-low line cannot
          // retrigger a frame.
          cnt <= '0;
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_r.sv
// -----------------------------------------------------------------------------
// tb_serial_r : self-checking bench for serial_r.
// Table of directed frames with hand-computed results, followed by hand
// sequences for latency, glitch rejection, back-to-back frames, reset during
// a frame and (majority build) spike rejection.
// -----------------------------------------------------------------------------
module tb_serial_r;

`ifdef SERIAL_R_MAJORITY_EN
  localparam int unsigned BIT   = 64;
  localparam int unsigned EXTRA = 10;
`else
  localparam int unsigned BIT   = 16;
  localparam int unsigned EXTRA = 0;
`endif
  localparam int unsigned HALF = BIT / 2;
  localparam int unsigned LAT  = 2 + HALF + 9 * BIT + EXTRA;

  logic       m_clock = 1'b0;
  logic       p_reset_n;
  logic       RDX;
  logic [7:0] dataout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  serial_r #(.BIT_CYC(BIT)) dut (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .RDX       (RDX),
    .dataout   (dataout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 m_clock = ~m_clock;

  int cyc = 0;
  always @(posedge m_clock) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         vcnt = 0;
  int         fcnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         vcyc = 0;
  logic [7:0] vq[$];
  logic       valid_d = 1'b0;
  logic       ferr_d = 1'b0;
  logic       busy_after = 1'b1;

  always @(negedge m_clock) begin
    if (valid_d) busy_after = busy;
    if (valid) begin
      vcnt++;
      vq.push_back(dataout);
      vcyc = cyc;
    end
    if (frame_err) fcnt++;
    if (valid && frame_err) both_cnt++;
    if ((valid && valid_d) || (frame_err && ferr_d)) long_cnt++;
    valid_d = valid;
    ferr_d  = frame_err;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    RDX = 1'b1;
    repeat (n) @(negedge m_clock);
  endtask

  task automatic drive_bit(input logic b, input int unsigned n);
    RDX = b;
    repeat (n) @(negedge m_clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    drive_bit(1'b0, BIT);
    for (int unsigned i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (stop_ok) drive_bit(1'b1, BIT);
    else         drive_bit(1'b0, BIT + 12);
    RDX = 1'b1;
  endtask

  // Drive the first n cycles of a frame, inverting the line for one cycle
  // at cycle indices s0 and s1 (counted from the start-bit edge).
  task automatic send_spiked(input logic [7:0] d, input int unsigned n,
                             input int unsigned s0, input int unsigned s1);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int unsigned c = 0; c < n; c++) begin
      RDX = f[c / BIT] ^ ((c == s0) || (c == s1));
      @(negedge m_clock);
    end
    RDX = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, f0, t0, lat;

    vecs[0] = '{8'hC8, 1'b1, 1, 0, 8'hC8};
    vecs[1] = '{8'h55, 1'b0, 0, 1, 8'hC8};
    vecs[2] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[6] = '{8'h81, 1'b0, 0, 1, 8'h3C};
    vecs[7] = '{8'h7E, 1'b1, 1, 0, 8'h7E};

    p_reset_n = 1'b0;
    RDX       = 1'b1;
    repeat (3) @(negedge m_clock);
    chk("reset_dataout", {24'h0, dataout}, 32'h00);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    p_reset_n = 1'b1;
    idle(BIT);

    // Table-driven frames.
    for (int unsigned i = 0; i < 8; i++) begin
      v0 = vcnt;
      f0 = fcnt;
      send_frame(vecs[i].data, vecs[i].stop_ok);
      idle(BIT);
      chk($sformatf("vec%0d_valid_count", i), vcnt - v0, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ferr_count", i), fcnt - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_dataout", i), {24'h0, dataout}, {24'h0, vecs[i].exp_dout});
      if (vecs[i].exp_valid == 1 && vq.size() > 0)
        chk($sformatf("vec%0d_pulse_byte", i), {24'h0, vq[$]}, {24'h0, vecs[i].exp_dout});
    end

    // Latency from the RDX falling edge to valid, and busy after the pulse.
    v0 = vcnt;
    t0 = cyc;
    send_frame(8'h5A, 1'b1);
    idle(BIT);
    chk("lat_valid_count", vcnt - v0, 1);
    lat = vcyc - t0 - 1;
    if (!(lat >= int'(LAT) - 1 && lat <= int'(LAT) + 1)) begin
      $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
      errors++;
    end
    checks++;
    chk("busy_after_pulse", {31'h0, busy_after}, 32'h0);

    // 5-cycle low glitch on an idle line.
    v0 = vcnt;
    f0 = fcnt;
    RDX = 1'b0;
    repeat (4) @(negedge m_clock);
    chk("glitch_busy_high", {31'h0, busy}, 32'h1);
    @(negedge m_clock);
    RDX = 1'b1;
    repeat (HALF + 3) @(negedge m_clock);
    chk("glitch_busy_low", {31'h0, busy}, 32'h0);
    idle(2 * BIT);
    chk("glitch_no_valid", vcnt - v0, 0);
    chk("glitch_no_ferr", fcnt - f0, 0);

    // Back-to-back frames with no idle gap.
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(BIT);
    chk("b2b_valid_count", vcnt - v0, 3);
    chk("b2b_ferr_count", fcnt - f0, 0);
    if (vq.size() >= 3) begin
      chk("b2b_byte0", {24'h0, vq[vq.size() - 3]}, 32'h00);
      chk("b2b_byte1", {24'h0, vq[vq.size() - 2]}, 32'hFF);
      chk("b2b_byte2", {24'h0, vq[vq.size() - 1]}, 32'h3C);
    end

    // Reset in the middle of data bit 4 of frame 0x81.
    v0 = vcnt;
    f0 = fcnt;
    send_spiked(8'h81, 5 * BIT + HALF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    p_reset_n = 1'b0;
    #1;
    chk("midrst_dataout", {24'h0, dataout}, 32'h00);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    repeat (3) @(negedge m_clock);
    p_reset_n = 1'b1;
    idle(2 * BIT);
    chk("midrst_no_valid", vcnt - v0, 0);
    chk("midrst_no_ferr", fcnt - f0, 0);
    chk("midrst_dataout_held", {24'h0, dataout}, 32'h00);
    send_frame(8'h7E, 1'b1);
    idle(BIT);
    chk("postrst_valid_count", vcnt - v0, 1);
    chk("postrst_dataout", {24'h0, dataout}, 32'h7E);

`ifdef SERIAL_R_MAJORITY_EN
    // One-cycle inverted spikes on the centre sample of data bits 0 and 1.
    v0 = vcnt;
    send_spiked(8'h96, 10 * BIT, BIT + HALF + 1, 2 * BIT + HALF + 2);
    idle(BIT);
    chk("spike_valid_count", vcnt - v0, 1);
    chk("spike_dataout", {24'h0, dataout}, 32'h96);
`endif

    chk("never_valid_and_ferr", both_cnt, 0);
    chk("pulses_one_cycle", long_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
